// File: rtl/serial_rx_display.sv
// 8N1 serial receiver that shifts received digit codes (0..10) into a
// six-digit display word for the segment-scan driver.
module serial_rx_display #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        busy,
    output logic [23:0] number_sig,
    output logic [7:0]  byte_count
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q, busy_d;
    logic [23:0] number_q, number_d;
    logic [7:0]  byte_count_q, byte_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            number_q     <= 24'hAAAAAA;
            byte_count_q <= '0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            number_q     <= number_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        number_d     = number_q;
        byte_count_d = byte_count_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        byte_count_d = byte_count_q + 8'd1;
                        // Only digit codes 0..9 and the blank glyph reach the display.
                        if (shift_q[7:4] == 4'd0 && shift_q[3:0] <= 4'd10)
                            number_d = {number_q[19:0], shift_q[3:0]};
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign number_sig = number_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_serial_rx_display.sv
// Directed bench for serial_rx_display at 16 clocks per bit.
module tb_serial_rx_display;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [7:0]  data;
    logic        data_valid;
    logic        frame_err;
    logic        busy;
    logic [23:0] number_sig;
    logic [7:0]  byte_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int dv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int last_dv_cyc = 0;
    int fall_cyc = 0;
    int dv0, fe0, lat;

    serial_rx_display #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .number_sig (number_sig),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt++;
            last_dv_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (data_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
    endtask

    // Leaves rx at the stop-bit level when it returns.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        fall_cyc = cyc;
        wait_cycles(C);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(C);
        end
        rx = stop_bit;
        wait_cycles(C);
        $display("tx byte 0x%02h stop=%0d -> data=0x%02h number_sig=%06h byte_count=%0d",
                 b, stop_bit, data, number_sig, byte_count);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(3);
        rst = 1'b0;

        // Idle line after reset
        wait_cycles(100);
        check("idle_data", 32'(data), 32'h0);
        check("idle_number", 32'(number_sig), 32'hAAAAAA);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_count", 32'(byte_count), 32'h0);
        check("idle_pulses", 32'(dv_cnt + fe_cnt), 32'h0);

        // Single digit byte and its latency
        send_byte(8'h05, 1'b1);
        lat = last_dv_cyc - fall_cyc;
        check("single_dv", 32'(dv_cnt), 32'd1);
        check("single_lat", 32'((lat >= 154 && lat <= 156) ? 155 : lat), 32'd155);
        check("single_data", 32'(data), 32'h05);
        check("single_number", 32'(number_sig), 32'hAAAAA5);
        check("single_count", 32'(byte_count), 32'd1);

        // Back-to-back digits after a fresh reset
        do_reset();
        dv0 = dv_cnt;
        for (int d = 1; d <= 6; d++) send_byte(8'(d), 1'b1);
        wait_cycles(4);
        check("b2b_dv", 32'(dv_cnt - dv0), 32'd6);
        check("b2b_number", 32'(number_sig), 32'h123456);
        check("b2b_count", 32'(byte_count), 32'd6);

        // Non-digit bytes: counted but not displayed
        send_byte(8'h41, 1'b1);
        send_byte(8'h0B, 1'b1);
        check("nondigit_data", 32'(data), 32'h0B);
        check("nondigit_count", 32'(byte_count), 32'd8);
        check("nondigit_number", 32'(number_sig), 32'h123456);

        // Framing error with the line held low afterwards
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        send_byte(8'h37, 1'b0);
        wait_cycles(40);
        check("ferr_busy_low", 32'(busy), 32'h1);
        check("ferr_fe", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_dv", 32'(dv_cnt - dv0), 32'd0);
        check("ferr_data", 32'(data), 32'h0B);
        check("ferr_count", 32'(byte_count), 32'd8);
        rx = 1'b1;
        wait_cycles(5);
        check("ferr_busy_idle", 32'(busy), 32'h0);
        check("ferr_fe_after", 32'(fe_cnt - fe0), 32'd1);

        // Short glitch on the line
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        rx = 1'b0;
        wait_cycles(5);
        rx = 1'b1;
        wait_cycles(30);
        $display("glitch 5 cycles -> busy=%0d", busy);
        check("glitch_pulses", 32'((dv_cnt - dv0) + (fe_cnt - fe0)), 32'd0);
        check("glitch_busy", 32'(busy), 32'h0);

        // Reset in the middle of the data bits of a 0x09 frame
        rx = 1'b0;
        wait_cycles(C);
        rx = 1'b1;
        wait_cycles(C);
        rx = 1'b0;
        wait_cycles(C / 2);
        check("mid_busy_before", 32'(busy), 32'h1);
        do_reset();
        $display("reset mid-frame -> data=0x%02h number_sig=%06h", data, number_sig);
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_number", 32'(number_sig), 32'hAAAAAA);
        check("mid_rst_count", 32'(byte_count), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        wait_cycles(30);
        send_byte(8'h09, 1'b1);
        check("post_rst_data", 32'(data), 32'h09);
        check("post_rst_number", 32'(number_sig), 32'hAAAAA9);
        check("post_rst_count", 32'(byte_count), 32'd1);

        // Display boundary: code 10 (blank) accepted, 0 accepted
        send_byte(8'h0A, 1'b1);
        send_byte(8'h00, 1'b1);
        check("blank_zero_number", 32'(number_sig), 32'hAAA9A0);
        check("blank_zero_count", 32'(byte_count), 32'd3);

        check("dv_fe_exclusive", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_rx_display.md
Name: serial_rx_display

Overview:
- UART-style 8N1 serial receiver: the receiving end of the byte link driven by the demo control logic.
- Recovers each byte from the `rx` line, flags framing errors and pulses `data_valid`.
- Shifts accepted digit codes into a 6-digit BCD display word.
- Feeds the downstream segment-scan driver in the same format the transmit side uses: 4-bit digit codes, with code 10 as the blank/separator glyph.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit (50 MHz / 9600 baud); legal range 4 to 65535.
- HALF_BIT, CLKS_PER_BIT/2, sample offset from start-bit edge to mid-bit.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  last correctly framed byte.
- data_valid  output  1  one-cycle pulse when `data` updates.
- frame_err  output  1  one-cycle pulse on bad stop bit.
- busy  output  1  high while not in IDLE.
- number_sig  output  24  six 4-bit digit codes; [23:20] is the oldest digit, [3:0] the newest.
- byte_count  output  8  count of good bytes received; wraps 255 to 0.

Behaviour:
- Reset (rst=1 at posedge clk), regardless of state or mid-frame:
  - FSM goes to IDLE; all counters clear.
  - data=0, data_valid=0, frame_err=0, busy=0, number_sig=24'hAAAAAA (all blank), byte_count=0.
  - Both synchronizer flops load 1.
- Input synchronizer:
  - `rx` passes through 2 flops to give rx_s.
  - Only rx_s is used by the logic below.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s==0, clear the bit counter and go to START.
  - START: at bit counter == HALF_BIT-1:
    - if rx_s==0, clear the counter and go to DATA;
    - else go to IDLE (glitch rejected; no output pulse).
  - DATA: at counter == CLKS_PER_BIT-1:
    - shift rx_s into the shift register LSB-first (new bit enters at [7], register shifts right);
    - clear the counter; increment bit_idx.
    - After the 8th bit (bit_idx 7 to 0 wrap), go to STOP.
  - STOP: at counter == CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: data<=shift register, data_valid=1 for one cycle, byte_count+1, go to IDLE.
    - rx_s==0: frame_err=1 for one cycle, data unchanged, byte_count unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break or line-low condition from retriggering continuously.
- Display update, same cycle as data_valid, using the received byte b:
  - If b[7:4]==0 and b[3:0]<=10: number_sig <= {number_sig[19:0], b[3:0]}.
  - Otherwise number_sig is unchanged. data_valid still pulses and byte_count still increments.
- Outputs:
  - busy = (state != IDLE), registered.
  - data_valid and frame_err are never high in the same cycle.
- Latency: data_valid rises HALF_BIT + 9*CLKS_PER_BIT + 3 cycles (±1) after the `rx` falling edge. The 3 cycles cover 2 sync stages plus IDLE detection.
- A new start bit is accepted from the first IDLE cycle after STOP, so back-to-back frames with a one-bit stop are supported.
- Bit counter width is 16 bits; it never wraps within a legal frame.

Test Plan:
- Sim with CLKS_PER_BIT=16. Apply reset, then rx=1 held for 100 cycles -> data=0, number_sig=24'hAAAAAA, busy=0, no pulses.
- Send byte 0x05 (start, bits LSB-first, stop=1) -> one data_valid pulse at 8+144+3 = 155 ±1 cycles after the falling edge; data=0x05; number_sig=24'hAAAAA5; byte_count=1.
- Send 0x01..0x06 back-to-back with one stop bit -> six data_valid pulses; number_sig=24'h123456; byte_count=6.
- Send 0x41 ('A') then 0x0B -> data ends at 0x0B, byte_count increments by 2, number_sig unchanged.
- Send 0x37 with stop bit=0, holding rx low for 40 cycles afterwards -> frame_err pulse once, no data_valid, data unchanged, busy high until rx returns high, then IDLE.
- Pulse rx low for 5 cycles (glitch) -> no pulses, back to IDLE. Assert rst mid-DATA of a 0x09 frame -> all outputs return to reset values; the next clean 0x09 frame is received correctly.
